// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared ALU codes, forward-select encodings and datapath width
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_BLT  = 4'b1000;
    localparam logic [3:0] ALU_BGE  = 4'b1001;
    localparam logic [3:0] ALU_BLTU = 4'b1010;
    localparam logic [3:0] ALU_BGEU = 4'b1011;
    localparam logic [3:0] ALU_BEQ  = 4'b1100;
    localparam logic [3:0] ALU_BNE  = 4'b1101;
    localparam logic [3:0] ALU_SRA  = 4'b1110;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    function automatic logic is_branch(input logic [3:0] code);
        return (code == ALU_BLT) || (code == ALU_BGE) || (code == ALU_BLTU) ||
               (code == ALU_BGEU) || (code == ALU_BEQ) || (code == ALU_BNE);
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU with branch condition flag
import riscv_pkg::*;

module alu #(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      code,
    output logic [XLEN-1:0] result,
    output logic            cond
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] diff;
    logic            lt_s;
    logic            lt_u;
    logic            eq;

    assign shamt = b[4:0];
    assign diff  = a - b;
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    assign eq    = a == b;

    always_comb begin
        result = '0;
        cond   = 1'b0;
        case (code)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = diff;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            // Branches still produce A - B so the result bus stays meaningful.
            ALU_BEQ:  begin result = diff; cond = eq;    end
            ALU_BNE:  begin result = diff; cond = !eq;   end
            ALU_BLT:  begin result = diff; cond = lt_s;  end
            ALU_BGE:  begin result = diff; cond = !lt_s; end
            ALU_BLTU: begin result = diff; cond = lt_u;  end
            ALU_BGEU: begin result = diff; cond = !lt_u; end
            default:  begin result = '0;   cond = 1'b0;  end
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: operand forwarding, ALU, branch resolve, EX/MEM register
import riscv_pkg::*;

module execute_stage #(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [3:0]      alu_control,
    input  logic            alu_src,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] wb_result,
    input  logic [4:0]      rd_in,
    input  logic            reg_write_in,
    input  logic            mem_write_in,
    input  logic [1:0]      result_src_in,
    input  logic            stall,
    input  logic            flush,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_store_data,
    output logic [4:0]      mem_rd,
    output logic            mem_reg_write,
    output logic            mem_mem_write,
    output logic [1:0]      mem_result_src,
    output logic [XLEN-1:0] mem_pc_plus4
);

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_cond;

    always_comb begin
        case (forward_a)
            FWD_WB:  fwd_a = wb_result;
            FWD_MEM: fwd_a = mem_alu_result;
            default: fwd_a = rs1_data;
        endcase
        case (forward_b)
            FWD_WB:  fwd_b = wb_result;
            FWD_MEM: fwd_b = mem_alu_result;
            default: fwd_b = rs2_data;
        endcase
    end

    assign op_b = alu_src ? imm : fwd_b;

    alu #(.XLEN(XLEN)) u_alu (
        .a      (fwd_a),
        .b      (op_b),
        .code   (alu_control),
        .result (alu_result),
        .cond   (alu_cond)
    );

    assign branch_taken  = !rst && in_valid && is_branch(alu_control) && alu_cond;
    assign branch_target = pc + imm;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_alu_result <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_result_src <= '0;
            mem_pc_plus4   <= '0;
        end else if (flush) begin
            // Bubble: kill side effects only; data fields are don't-care downstream.
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_mem_write <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= in_valid;
            mem_alu_result <= alu_result;
            mem_store_data <= fwd_b;
            mem_rd         <= rd_in;
            mem_reg_write  <= in_valid && reg_write_in;
            mem_mem_write  <= in_valid && mem_write_in;
            mem_result_src <= result_src_in;
            mem_pc_plus4   <= pc + XLEN'(4);
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  alu_control;
    logic        alu_src;
    logic [31:0] rs1_data, rs2_data, imm, pc, wb_result;
    logic [1:0]  forward_a, forward_b;
    logic [4:0]  rd_in;
    logic        reg_write_in, mem_write_in;
    logic [1:0]  result_src_in;
    logic        stall, flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_valid;
    logic [31:0] mem_alu_result, mem_store_data, mem_pc_plus4;
    logic [4:0]  mem_rd;
    logic        mem_reg_write, mem_mem_write;
    logic [1:0]  mem_result_src;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_control(alu_control),
        .alu_src(alu_src), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .pc(pc), .forward_a(forward_a), .forward_b(forward_b), .wb_result(wb_result),
        .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_write_in(mem_write_in),
        .result_src_in(result_src_in), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
        .mem_result_src(mem_result_src), .mem_pc_plus4(mem_pc_plus4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic src, input logic [31:0] im);
        alu_control = code;
        rs1_data    = a;
        rs2_data    = b;
        alu_src     = src;
        imm         = im;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; forward_a = 2'b00; forward_b = 2'b00;
        wb_result = 32'h0; pc = 32'h0; rd_in = 5'd9; reg_write_in = 1'b1;
        mem_write_in = 1'b1; result_src_in = 2'b10; stall = 1'b0; flush = 1'b0;
        set_op(4'b1100, 32'd4, 32'd4, 1'b0, 32'h0);
        step();
        check("rst_valid", mem_valid, 0);
        check("rst_alu", mem_alu_result, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_pc4", mem_pc_plus4, 0);
        check("rst_branch", branch_taken, 0);

        rst = 1'b0; mem_write_in = 1'b0; result_src_in = 2'b01;
        rd_in = 5'd3; pc = 32'h40;
        set_op(4'b0001, 32'd5, 32'd7, 1'b0, 32'h0);
        step();
        check("sub", mem_alu_result, 32'hFFFF_FFFE);
        check("sub_valid", mem_valid, 1);
        check("sub_rd", mem_rd, 3);
        check("sub_regw", mem_reg_write, 1);
        check("sub_memw", mem_mem_write, 0);
        check("sub_src", mem_result_src, 2'b01);
        check("sub_pc4", mem_pc_plus4, 32'h44);
        check("sub_store", mem_store_data, 7);

        set_op(4'b0101, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0);
        step();
        check("slt", mem_alu_result, 1);
        set_op(4'b1111, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0);
        step();
        check("sltu", mem_alu_result, 0);

        set_op(4'b1110, 32'h8000_0000, 32'd0, 1'b1, 32'h24);
        step();
        check("sra", mem_alu_result, 32'hF800_0000);
        set_op(4'b0111, 32'h8000_0000, 32'd0, 1'b1, 32'h24);
        step();
        check("srl", mem_alu_result, 32'h0800_0000);
        set_op(4'b0110, 32'h0000_0003, 32'd0, 1'b1, 32'h21);
        step();
        check("sll", mem_alu_result, 32'h6);

        pc = 32'h100;
        set_op(4'b1000, 32'hFFFF_FFFD, 32'd2, 1'b0, 32'h20);
        #1;
        check("blt_taken", branch_taken, 1);
        check("blt_target", branch_target, 32'h120);
        step();
        check("blt_result", mem_alu_result, 32'hFFFF_FFFB);
        alu_control = 4'b1010;
        #1;
        check("bltu_taken", branch_taken, 0);
        alu_control = 4'b1000; in_valid = 1'b0;
        #1;
        check("blt_invalid", branch_taken, 0);
        step();
        check("inv_valid", mem_valid, 0);
        check("inv_regw", mem_reg_write, 0);
        in_valid = 1'b1;
        set_op(4'b1101, 32'd7, 32'd7, 1'b0, 32'h20);
        #1;
        check("bne_equal", branch_taken, 0);
        set_op(4'b1011, 32'd2, 32'hFFFF_FFFD, 1'b0, 32'h20);
        #1;
        check("bgeu_taken", branch_taken, 0);

        set_op(4'b0000, 32'd3, 32'd4, 1'b0, 32'h0);
        step();
        check("add", mem_alu_result, 7);
        forward_a = 2'b10;
        set_op(4'b0000, 32'd100, 32'd0, 1'b1, 32'd1);
        step();
        check("fwd_mem", mem_alu_result, 8);
        forward_a = 2'b00; forward_b = 2'b01; wb_result = 32'hAB;
        set_op(4'b0000, 32'd0, 32'd55, 1'b1, 32'd5);
        step();
        check("fwd_wb_store", mem_store_data, 32'hAB);
        check("fwd_wb_alu", mem_alu_result, 5);
        forward_a = 2'b11; forward_b = 2'b11;
        set_op(4'b0000, 32'd9, 32'd1, 1'b0, 32'd0);
        step();
        check("fwd_11", mem_alu_result, 10);
        forward_a = 2'b00; forward_b = 2'b00;

        rd_in = 5'd7; mem_write_in = 1'b1; pc = 32'h200;
        set_op(4'b0000, 32'd10, 32'd20, 1'b0, 32'd0);
        step();
        check("ctl_load", mem_alu_result, 30);
        check("ctl_memw", mem_mem_write, 1);
        stall = 1'b1; rd_in = 5'd2; mem_write_in = 1'b0; pc = 32'h300;
        set_op(4'b0000, 32'd1, 32'd1, 1'b0, 32'd0);
        step();
        step();
        check("stall_alu", mem_alu_result, 30);
        check("stall_rd", mem_rd, 7);
        check("stall_pc4", mem_pc_plus4, 32'h204);
        check("stall_memw", mem_mem_write, 1);
        flush = 1'b1;
        step();
        check("flush_valid", mem_valid, 0);
        check("flush_regw", mem_reg_write, 0);
        check("flush_memw", mem_mem_write, 0);
        check("flush_data", mem_alu_result, 30);

        flush = 1'b0; stall = 1'b0;
        step();
        check("reload", mem_alu_result, 2);
        stall = 1'b1; rst = 1'b1;
        step();
        check("rst_stall_valid", mem_valid, 0);
        check("rst_stall_alu", mem_alu_result, 0);
        check("rst_stall_pc4", mem_pc_plus4, 0);
        check("rst_stall_rd", mem_rd, 0);
        rst = 1'b0; stall = 1'b0;
        set_op(4'b0010, 32'hF0F0, 32'h0FF0, 1'b0, 32'd0);
        step();
        check("post_rst_and", mem_alu_result, 32'h00F0);
        check("post_rst_valid", mem_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
